// File: rtl/mem_burst_bridge_pkg.sv
// Shared definitions for the cache-to-narrow-bus burst bridge.
package mem_burst_bridge_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 28;
  localparam int unsigned DEFAULT_WORD_W = 32;
  localparam int unsigned DEFAULT_BEAT_N = 4;

  localparam int unsigned BLOCK_W   = DEFAULT_WORD_W * DEFAULT_BEAT_N;
  localparam int unsigned BEAT_BITS = $clog2(DEFAULT_BEAT_N);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_burst_bridge.sv
// Splits each cache block read/write into BEAT_N word beats on a narrow memory
// bus and returns completion to the cache with a one-cycle mem_ready pulse.
// Every output comes straight from a register.
module mem_burst_bridge
  import mem_burst_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned WORD_W = DEFAULT_WORD_W,
  parameter int unsigned BEAT_N = DEFAULT_BEAT_N
) (
  input  logic                                clk,
  input  logic                                proc_reset,
  input  logic                                mem_read,
  input  logic                                mem_write,
  input  logic [ADDR_W-1:0]                   mem_addr,
  input  logic [WORD_W*BEAT_N-1:0]            mem_wdata,
  output logic [WORD_W*BEAT_N-1:0]            mem_rdata,
  output logic                                mem_ready,
  output logic                                bus_req,
  output logic                                bus_we,
  output logic [ADDR_W+$clog2(BEAT_N)-1:0]    bus_addr,
  output logic [WORD_W-1:0]                   bus_wdata,
  input  logic [WORD_W-1:0]                   bus_rdata,
  input  logic                                bus_ack
);

  localparam int unsigned BlockW   = WORD_W * BEAT_N;
  localparam int unsigned BeatBits = $clog2(BEAT_N);
  localparam logic [BeatBits-1:0] LastBeat = BeatBits'(BEAT_N - 1);

  state_e                       state_q, state_d;
  logic [BeatBits-1:0]          beat_q, beat_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [WORD_W-1:0]            data_q [BEAT_N];
  logic [WORD_W-1:0]            data_d [BEAT_N];
  logic                         we_q, we_d;
  logic                         req_q, req_d;
  logic                         ready_q, ready_d;
  logic [BlockW-1:0]            rdata_q, rdata_d;
  logic [ADDR_W+BeatBits-1:0]   baddr_q, baddr_d;
  logic [WORD_W-1:0]            bwdata_q, bwdata_d;
  logic [BeatBits-1:0]          beat_nxt;

  assign beat_nxt = beat_q + 1'b1;

  // Next-state and registered-output computation for the burst FSM.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    req_d    = req_q;
    ready_d  = 1'b0;
    rdata_d  = rdata_q;
    baddr_d  = baddr_q;
    bwdata_d = bwdata_q;
    unique case (state_q)
      StIdle: begin
        // Write has priority when both requests are raised together.
        if (mem_write) begin
          for (int k = 0; k < BEAT_N; k++) begin
            data_d[k] = mem_wdata[k*WORD_W +: WORD_W];
          end
          addr_d   = mem_addr;
          we_d     = 1'b1;
          req_d    = 1'b1;
          beat_d   = '0;
          baddr_d  = {mem_addr, {BeatBits{1'b0}}};
          bwdata_d = mem_wdata[WORD_W-1:0];
          state_d  = StBurst;
        end else if (mem_read) begin
          addr_d   = mem_addr;
          we_d     = 1'b0;
          req_d    = 1'b1;
          beat_d   = '0;
          baddr_d  = {mem_addr, {BeatBits{1'b0}}};
          bwdata_d = '0;
          state_d  = StBurst;
        end
      end
      StBurst: begin
        if (bus_ack) begin
          if (!we_q) begin
            data_d[beat_q] = bus_rdata;
          end
          if (beat_q == LastBeat) begin
            req_d   = 1'b0;
            beat_d  = '0;
            ready_d = 1'b1;
            state_d = StDone;
            // Reads publish the assembled block; writes leave mem_rdata alone.
            if (!we_q) begin
              for (int k = 0; k < BEAT_N; k++) begin
                rdata_d[k*WORD_W +: WORD_W] = data_d[k];
              end
            end
          end else begin
            beat_d  = beat_nxt;
            baddr_d = {addr_q, beat_nxt};
            if (we_q) begin
              bwdata_d = data_q[beat_nxt];
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      addr_q   <= '0;
      for (int k = 0; k < BEAT_N; k++) begin
        data_q[k] <= '0;
      end
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      baddr_q  <= '0;
      bwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_wdata = bwdata_q;

endmodule

// File: tb/tb_mem_burst_bridge.sv
// Bench for mem_burst_bridge: a bus-side memory responder with programmable
// wait states, and a block-level reference memory predicting cache-side results.
module tb_mem_burst_bridge;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [27:0]  mem_addr = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         bus_req;
  logic         bus_we;
  logic [29:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [31:0]  bus_rdata = '0;
  logic         bus_ack = 1'b0;

  mem_burst_bridge dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int waits_cfg = 0;
  bit spur = 1'b0;
  int wcnt = 0;
  int stab_err = 0;
  int ready_cnt = 0;
  logic [29:0] held_a;
  logic [31:0] held_wd;

  typedef struct packed {
    logic [29:0] a;
    logic        we;
    logic [31:0] wd;
  } beat_t;
  beat_t log_q[$];

  logic [31:0]  bus_mem [logic [29:0]];
  logic [31:0]  ref_mem [logic [29:0]];
  logic [127:0] exp_rdata = '0;

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_ready === 1'b1) ready_cnt++;

  // Memory responder: acks each beat after waits_cfg wait cycles.
  always @(negedge clk) begin
    if (bus_req === 1'b1 && !proc_reset) begin
      if (wcnt == 0) begin
        held_a  = bus_addr;
        held_wd = bus_wdata;
      end else if (bus_addr !== held_a || bus_wdata !== held_wd) begin
        stab_err++;
      end
      if (wcnt >= waits_cfg) begin
        bus_ack = 1'b1;
        if (bus_we) begin
          bus_mem[bus_addr] = bus_wdata;
          bus_rdata = $urandom;
        end else begin
          bus_rdata = bus_mem.exists(bus_addr) ? bus_mem[bus_addr] : init_word(bus_addr);
        end
        log_q.push_back('{a: bus_addr, we: bus_we, wd: bus_wdata});
        wcnt = 0;
      end else begin
        bus_ack = 1'b0;
        bus_rdata = $urandom;
        wcnt++;
      end
    end else begin
      bus_ack = spur;
      bus_rdata = $urandom;
      wcnt = 0;
    end
  end

  // One cache transaction, checked against the reference memory.
  task automatic run_xfer(input bit rd, input bit wr, input logic [27:0] a,
                          input logic [127:0] wd, input int w, input string tag);
    int c;
    int lat;
    int exp_lat;
    bit seen;
    logic [127:0] blk;
    logic [1:0] kb;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_idle: got %b want 0", tag, mem_ready);
    end
    waits_cfg = w;
    log_q.delete();
    stab_err = 0;
    mem_read = rd;
    mem_write = wr;
    mem_addr = a;
    mem_wdata = wd;
    c = cyc;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) seen = 1'b1;
    end
    lat = cyc - c;
    mem_read = 1'b0;
    mem_write = 1'b0;
    exp_lat = 1 + 4 * (1 + w);
    if (wr) begin
      for (int k = 0; k < 4; k++) begin
        kb = 2'(k);
        ref_mem[{a, kb}] = wd[k*32 +: 32];
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        kb = 2'(k);
        blk[k*32 +: 32] = ref_rd({a, kb});
      end
      exp_rdata = blk;
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d (seen=%0b) want %0d", tag, lat, seen, exp_lat);
    end
    checks++;
    if (mem_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL %s rdata: got %h want %h", tag, mem_rdata, exp_rdata);
    end
    checks++;
    if (bus_req !== 1'b0) begin
      failures++;
      $display("FAIL %s req_after_done: got %b want 0", tag, bus_req);
    end
    checks++;
    if (log_q.size() != 4) begin
      failures++;
      $display("FAIL %s beat_count: got %0d want 4", tag, log_q.size());
    end
    for (int k = 0; k < log_q.size() && k < 4; k++) begin
      kb = 2'(k);
      checks++;
      if ({log_q[k].a, log_q[k].we} !== {a, kb, wr}) begin
        failures++;
        $display("FAIL %s beat%0d addr/we: got %h/%b want %h/%b", tag, k,
                 log_q[k].a, log_q[k].we, {a, kb}, wr);
      end
      if (wr) begin
        checks++;
        if (log_q[k].wd !== wd[k*32 +: 32]) begin
          failures++;
          $display("FAIL %s beat%0d wdata: got %h want %h", tag, k, log_q[k].wd, wd[k*32 +: 32]);
        end
      end
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL %s stable_during_wait: got %0d changes want 0", tag, stab_err);
    end
  endtask

  task automatic test_reset();
    #1 proc_reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, bus_we, mem_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 000", {bus_req, bus_we, mem_ready});
    end
    checks++;
    if ({bus_addr, bus_wdata} !== 62'd0) begin
      failures++;
      $display("FAIL reset_bus: got %h want 0", {bus_addr, bus_wdata});
    end
    checks++;
    if (mem_rdata !== 128'd0) begin
      failures++;
      $display("FAIL reset_rdata: got %h want 0", mem_rdata);
    end
    proc_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b want 0", bus_req);
    end
  endtask

  task automatic test_read_zero_wait();
    run_xfer(1'b1, 1'b0, 28'h0000123, '0, 0, "read0");
    checks++;
    if (log_q.size() < 4 || log_q[0].a !== 30'h000048C || log_q[3].a !== 30'h000048F) begin
      failures++;
      $display("FAIL read0_addr_range: got first/last %h/%h want 48c/48f",
               log_q.size() > 0 ? log_q[0].a : 30'h0, log_q.size() > 3 ? log_q[3].a : 30'h0);
    end
  endtask

  task automatic test_write_waits();
    logic [127:0] wd;
    wd = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    run_xfer(1'b0, 1'b1, 28'h0000200, wd, 2, "write2w");
    checks++;
    if (log_q.size() < 1 || log_q[0].wd !== 32'hAAAAAAAA) begin
      failures++;
      $display("FAIL write2w_first_word: got %h want aaaaaaaa",
               log_q.size() > 0 ? log_q[0].wd : 32'h0);
    end
    run_xfer(1'b1, 1'b0, 28'h0000200, '0, 1, "write2w_readback");
  endtask

  task automatic test_back_to_back();
    int r0;
    @(negedge clk);
    #1 r0 = ready_cnt;
    run_xfer(1'b0, 1'b1, 28'h0000010, {$urandom, $urandom, $urandom, $urandom}, 0, "b2b_wr");
    run_xfer(1'b1, 1'b0, 28'h0000020, '0, 0, "b2b_rd");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ready_cnt - r0 != 2) begin
      failures++;
      $display("FAIL b2b_ready_pulses: got %0d want 2", ready_cnt - r0);
    end
  endtask

  task automatic test_simultaneous();
    run_xfer(1'b1, 1'b1, 28'h0000031, {$urandom, $urandom, $urandom, $urandom}, 1, "both");
    run_xfer(1'b1, 1'b0, 28'h0000031, '0, 0, "both_readback");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    waits_cfg = 1;
    log_q.delete();
    mem_read = 1'b1;
    mem_addr = 28'h0000077;
    for (int i = 0; i < 50 && log_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (log_q.size() < 2 || bus_req !== 1'b1) begin
      failures++;
      $display("FAIL midburst_setup: got beats=%0d req=%b want >=2/1", log_q.size(), bus_req);
    end
    #2 proc_reset = 1'b1;
    #1;
    checks++;
    if ({bus_req, mem_ready, bus_we} !== 3'b000 || bus_addr !== 30'd0) begin
      failures++;
      $display("FAIL async_reset: got req=%b rdy=%b we=%b addr=%h want 0", bus_req, mem_ready,
               bus_we, bus_addr);
    end
    checks++;
    if (mem_rdata !== 128'd0) begin
      failures++;
      $display("FAIL async_reset_rdata: got %h want 0", mem_rdata);
    end
    exp_rdata = '0;
    mem_read = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    run_xfer(1'b1, 1'b0, 28'h0000077, '0, 1, "after_reset_rd");
  endtask

  task automatic test_spurious_ack();
    int r0;
    @(negedge clk);
    #1 r0 = ready_cnt;
    spur = 1'b1;
    repeat (6) @(negedge clk);
    spur = 1'b0;
    #1;
    checks++;
    if (ready_cnt != r0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL spurious_ack: got pulses=%0d req=%b want 0/0", ready_cnt - r0, bus_req);
    end
    run_xfer(1'b1, 1'b0, 28'h0000123, '0, 0, "after_spurious");
  endtask

  task automatic test_random();
    bit wr;
    bit rd;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      run_xfer(rd, wr, 28'h0000100 + 28'($urandom_range(0, 7)),
               {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_burst();
    test_spurious_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_burst_bridge.md
Name: mem_burst_bridge

Overview:
- Sits directly downstream of the 2-way cache's memory port. Converts each 128-bit block read or write into four 32-bit beats on a narrow word-addressed memory bus.
- Returns the result to the cache with a single-cycle mem_ready pulse.
- Lets the cache's write-back followed by allocate sequence run back-to-back without idle cycles being lost.

Parameters:
- ADDR_W, 28, block address width on the cache side (word address = ADDR_W+2 bits).
- WORD_W, 32, memory bus data width.
- BEAT_N, 4, beats per block (block width = WORD_W*BEAT_N = 128).

Ports:
- clk  in  1  system clock, rising edge
- proc_reset  in  1  asynchronous, active-high reset
- mem_read  in  1  cache block read request, level, held until mem_ready
- mem_write  in  1  cache block write request, level, held until mem_ready
- mem_addr  in  28  block address
- mem_wdata  in  128  write block; word k = bits 32k+31:32k
- mem_rdata  out  128  read block, same word order
- mem_ready  out  1  one-cycle completion pulse
- bus_req  out  1  beat request to memory
- bus_we  out  1  1 = write beat
- bus_addr  out  30  word address = {block_addr, beat}
- bus_wdata  out  32  write beat data
- bus_rdata  in  32  read beat data, valid with bus_ack
- bus_ack  in  1  beat accepted/completed; may be asserted in the same cycle as bus_req

Behaviour:
- Reset: proc_reset asserted at any time (including mid-burst) immediately clears all registers: state=IDLE, beat=0, mem_ready=0, mem_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0. An in-flight burst is abandoned and not resumed.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states:
  - IDLE: if mem_write, latch addr and wdata, set bus_we=1 and go to BURST. Else if mem_read, latch addr, set bus_we=0 and go to BURST. If both are high, write wins.
  - BURST: bus_req=1, bus_addr={addr,beat}, bus_wdata=word[beat]. On bus_ack: for a read, capture bus_rdata into word[beat]; then beat increments. When bus_ack arrives with beat==BEAT_N-1, go to DONE, deassert bus_req and reset beat to 0.
  - DONE: mem_ready=1 for exactly one cycle; for reads, mem_rdata carries the assembled block. Then go to IDLE.
- bus_req stays high across beats; bus_addr and bus_wdata change only on the edge after an ack and are stable while waiting for ack.
- Latency: request seen in IDLE at cycle T gives the first beat at T+1. With zero-wait ack, mem_ready occurs at T+5 (reads and writes). Each bus wait cycle adds 1.
- mem_rdata holds its value until the next read's DONE; writes never change it.
- Requests present in the DONE cycle are ignored; the cache drops its request there anyway.
- A new request in the cycle after DONE (IDLE) is accepted at once. This covers the write-back then allocate back-to-back case.
- bus_ack while bus_req=0 is ignored.
- beat wraps only through the DONE reset; no partial bursts.
- Request inputs are sampled only in IDLE; changes during BURST have no effect.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, BURST=1, DONE=2)
  - ADDR_W, WORD_W and BEAT_N defaults
  - derived BLOCK_W=128 and BEAT_BITS=2
- Single module; no natural sub-module. The beat counter and word mux are inline.

Test Plan:
- Read, zero-wait: mem_read with mem_addr=28'h0000123, memory returns bus_rdata=addr-based words → bus_addr 30'h000048C..48F in consecutive cycles; mem_ready at T+5 with mem_rdata={w3,w2,w1,w0} in correct order.
- Write, 2 wait cycles per beat: mem_write with mem_wdata=128'hDDDD...CCCC...BBBB...AAAA → bus_wdata 32'hAAAAAAAA first, held during waits; mem_ready at T+13; mem_rdata unchanged.
- Back-to-back: write to block 0x10, then the cache raises mem_read for block 0x20 the cycle after mem_ready → read burst starts in the next cycle with no dropped request; exactly two mem_ready pulses.
- Simultaneous mem_read=mem_write=1 → write burst (bus_we=1) executes.
- Reset asserted mid-burst after beat 1 → bus_req and mem_ready go 0 asynchronously; after release the next read completes normally from beat 0.
- Spurious bus_ack in IDLE → no state change, no mem_ready.
